// File: rtl/mod3_bit_serializer_if.sv
// Load handshake and serial-output bundle between a word source and the
// mod-3 bit serializer.
interface mod3_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sel;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
    logic [1:0]       rem;

    modport master (
        output load_valid, load_data,
        input  load_ready, sel, bit_valid, frame_start, frame_done, busy, rem
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sel, bit_valid, frame_start, frame_done, busy, rem
    );
endinterface

// File: rtl/mod3_bit_serializer.sv
// Parallel-to-serial feeder for the mod-3 divisibility FSM: shifts a word out
// MSB-first, one bit per divider tick, and tracks the running mod-3 residue.
module mod3_bit_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mod3_bit_serializer_if.slave  bus
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic               first_q, first_d;
    logic               sel_q, sel_d;
    logic               bit_valid_q, bit_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic [1:0]         rem_q, rem_d;

    // Residue of (2*r + b) mod 3; r==3 cannot occur
    function automatic logic [1:0] rem_step(input logic [1:0] r, input logic b);
        logic [1:0] res;
        case ({r, b})
            3'b000:  res = 2'd0;
            3'b001:  res = 2'd1;
            3'b010:  res = 2'd2;
            3'b011:  res = 2'd0;
            3'b100:  res = 2'd1;
            3'b101:  res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Free-running bit-rate divider, never resynchronised to loads
    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            first_q       <= 1'b0;
            sel_q         <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            rem_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            first_q       <= first_d;
            sel_q         <= sel_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            rem_q         <= rem_d;
        end
    end

    // Accept in IDLE ignores a coincident tick; SHIFT emits one bit per tick
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        first_d       = first_q;
        sel_d         = sel_q;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        busy_d        = busy_q;
        rem_d         = rem_q;

        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    shreg_d  = bus.load_data;
                    bitcnt_d = BIT_W'(WIDTH);
                    first_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sel_d         = shreg_q[WIDTH-1];
                    shreg_d       = shreg_q << 1;
                    bitcnt_d      = bitcnt_q - BIT_W'(1);
                    bit_valid_d   = 1'b1;
                    frame_start_d = first_q;
                    first_d       = 1'b0;
                    rem_d         = first_q ? {1'b0, shreg_q[WIDTH-1]}
                                            : rem_step(rem_q, shreg_q[WIDTH-1]);
                    if (bitcnt_q == BIT_W'(1)) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready  = (state_q == IDLE);
    assign bus.sel         = sel_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.rem         = rem_q;
endmodule

// File: tb/tb_mod3_bit_serializer.sv
// Bench for mod3_bit_serializer: a DIV=4 and a DIV=1 instance share stimulus and
// are compared every cycle against a prefix-arithmetic model of the frame.
module tb_mod3_bit_serializer;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         lv;
    logic [W-1:0] ld;

    always #5 clk = ~clk;

    mod3_bit_serializer_if #(.WIDTH(W)) bus0 ();
    mod3_bit_serializer_if #(.WIDTH(W)) bus1 ();

    assign bus0.load_valid = lv;
    assign bus0.load_data  = ld;
    assign bus1.load_valid = lv;
    assign bus1.load_data  = ld;

    mod3_bit_serializer #(.WIDTH(W), .DIV(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    mod3_bit_serializer #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    // Model: frame word, bits emitted so far, residue = value of emitted prefix mod 3
    logic         m_busy [2];
    logic         m_sel  [2];
    logic         m_bv   [2];
    logic         m_fs   [2];
    logic         m_fd   [2];
    logic [1:0]   m_rem  [2];
    logic [W-1:0] m_word [2];
    int           m_n    [2];
    int unsigned  m_e    [2];
    logic         tk;
    int           prefix;

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] = 1'b0; m_sel[i] = 1'b0; m_bv[i] = 1'b0; m_fs[i] = 1'b0;
                m_fd[i] = 1'b0; m_rem[i] = 2'd0; m_word[i] = '0; m_n[i] = 0; m_e[i] = 0;
            end else begin
                tk = ((m_e[i] % div_of(i)) == div_of(i) - 1);
                m_e[i] = m_e[i] + 1;
                m_bv[i] = 1'b0; m_fs[i] = 1'b0; m_fd[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (lv) begin
                        m_word[i] = ld; m_n[i] = 0; m_busy[i] = 1'b1;
                    end
                end else if (tk) begin
                    m_n[i]   = m_n[i] + 1;
                    prefix   = int'(m_word[i] >> (W - m_n[i]));
                    m_sel[i] = prefix[0];
                    m_rem[i] = 2'(prefix % 3);
                    m_bv[i]  = 1'b1;
                    m_fs[i]  = (m_n[i] == 1);
                    if (m_n[i] == W) begin
                        m_fd[i] = 1'b1; m_busy[i] = 1'b0;
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [W-1:0]   lg_sel [2];
    logic [2*W-1:0] lg_rem [2];
    int lg_n [2], fd_cnt [2], fs_cnt [2], bv_cnt [2], t_start [2], t_done [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare of both instances, plus logging of emitted bits
    task automatic compare_all();
        logic [7:0] act [2];
        logic [7:0] exp;
        cyc++;
        act[0] = {bus0.load_ready, bus0.sel, bus0.bit_valid, bus0.frame_start,
                  bus0.frame_done, bus0.busy, bus0.rem};
        act[1] = {bus1.load_ready, bus1.sel, bus1.bit_valid, bus1.frame_start,
                  bus1.frame_done, bus1.busy, bus1.rem};
        for (int i = 0; i < 2; i++) begin
            exp = {!m_busy[i], m_sel[i], m_bv[i], m_fs[i], m_fd[i], m_busy[i], m_rem[i]};
            chk((i == 0) ? "cycle_div4 {rdy,sel,bv,fs,fd,busy,rem}" : "cycle_div1 {rdy,sel,bv,fs,fd,busy,rem}",
                32'(act[i]), 32'(exp));
            if (act[i][5]) begin
                bv_cnt[i]++;
                if (act[i][4]) begin
                    lg_n[i] = 0; lg_sel[i] = '0; lg_rem[i] = '0;
                    fs_cnt[i]++; t_start[i] = cyc;
                end
                lg_sel[i] = {lg_sel[i][W-2:0], act[i][6]};
                lg_rem[i] = {lg_rem[i][2*W-3:0], act[i][1:0]};
                lg_n[i]++;
                if (act[i][3]) begin
                    fd_cnt[i]++; t_done[i] = cyc;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        lv = 1'b1; ld = w;
        for (int k = 0; k < 400; k++) begin
            if (bus0.load_ready) begin
                step();
                lv = 1'b0; lg_n[0] = 0;
                return;
            end
            step();
        end
        chk("send_timeout", 32'd0, 32'd1);
        lv = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            if (bus0.load_ready && bus1.load_ready) return;
            step();
        end
        chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bits0(input int n);
        for (int k = 0; k < 400; k++) begin
            if (lg_n[0] >= n) return;
            step();
        end
        chk("bits_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done0(input int f);
        for (int k = 0; k < 400; k++) begin
            if (fd_cnt[0] > f) return;
            step();
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    int b0, b1, f0, s0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            lg_sel[i] = '0; lg_rem[i] = '0; lg_n[i] = 0; fd_cnt[i] = 0;
            fs_cnt[i] = 0; bv_cnt[i] = 0; t_start[i] = 0; t_done[i] = 0;
        end
        reset = 1'b1; lv = 1'b0; ld = '0;
        repeat (3) step();
        chk("reset_outputs", 32'({bus0.load_ready, bus0.sel, bus0.bit_valid, bus0.frame_start,
                                  bus0.frame_done, bus0.busy, bus0.rem}), 32'h80);
        reset = 1'b0;

        // Idle with no load: no strobes at all
        b0 = bv_cnt[0]; b1 = bv_cnt[1];
        repeat (20) step();
        chk("idle_no_strobes", 32'(bv_cnt[0] - b0 + bv_cnt[1] - b1), 32'd0);

        // 0x05: DIV=1 bits back-to-back, final residue 5 mod 3 = 2
        send(8'h05); wait_idle();
        chk("div1_sel_0x05", 32'(lg_sel[1]), 32'h05);
        chk("div1_rem_0x05", 32'(lg_rem[1][1:0]), 32'd2);
        chk("div1_span", 32'(t_done[1] - t_start[1]), 32'd7);
        chk("div4_span", 32'(t_done[0] - t_start[0]), 32'd28);

        // 0x0F
        send(8'h0F); wait_idle();
        chk("sel_0x0F", 32'(lg_sel[0]), 32'h0F);
        chk("remseq_0x0F", 32'(lg_rem[0]), 32'h0044);
        chk("nbits_0x0F", 32'(lg_n[0]), 32'd8);

        // 0xB5 = 181, residues 1,2,2,2,1,0,0,1
        send(8'hB5); wait_idle();
        chk("sel_0xB5", 32'(lg_sel[0]), 32'hB5);
        chk("remseq_0xB5", 32'(lg_rem[0]), 32'h6A41);
        chk("model_rem_0xB5", 32'(m_rem[0]), 32'd1);

        // Back-to-back 0x07 then 0x08 with load_valid held
        s0 = fs_cnt[0]; f0 = fd_cnt[0];
        lv = 1'b1; ld = 8'h07;
        for (int k = 0; k < 50 && !bus0.load_ready; k++) step();
        step();
        ld = 8'h08;
        wait_done0(f0);
        chk("b2b_sel_0x07", 32'(lg_sel[0]), 32'h07);
        chk("b2b_rem_0x07", 32'(lg_rem[0][1:0]), 32'd1);
        chk("b2b_ready_after_done", 32'(bus0.load_ready), 32'd1);
        step();
        chk("b2b_second_accept", 32'({bus0.busy, bus0.load_ready}), 32'b10);
        lv = 1'b0;
        wait_idle();
        chk("b2b_sel_0x08", 32'(lg_sel[0]), 32'h08);
        chk("b2b_rem_0x08", 32'(lg_rem[0][1:0]), 32'd2);
        chk("b2b_frame_starts", 32'(fs_cnt[0] - s0), 32'd2);

        // 0x00 with 0xFF offered mid-frame: ignored until frame_done
        send(8'h00);
        wait_bits0(3);
        lv = 1'b1; ld = 8'hFF;
        chk("busy_not_ready", 32'(bus0.load_ready), 32'd0);
        f0 = fd_cnt[0];
        wait_done0(f0);
        chk("sel_0x00", 32'(lg_sel[0]), 32'h00);
        chk("remseq_0x00", 32'(lg_rem[0]), 32'h0000);
        step(); step();
        chk("pending_0xFF_accepted", 32'(bus0.busy), 32'd1);
        lv = 1'b0;
        wait_idle();
        chk("sel_0xFF", 32'(lg_sel[0]), 32'hFF);
        chk("remseq_0xFF", 32'(lg_rem[0]), 32'h4444);

        // Reset mid-frame on 0xAA after the 3rd bit, then 0x03
        send(8'hAA);
        wait_bits0(3);
        f0 = fd_cnt[0];
        #2 reset = 1'b1;
        #1;
        chk("midreset_div4", 32'({bus0.load_ready, bus0.sel, bus0.bit_valid, bus0.frame_start,
                                  bus0.frame_done, bus0.busy, bus0.rem}), 32'h80);
        chk("midreset_div1", 32'({bus1.load_ready, bus1.sel, bus1.bit_valid, bus1.frame_start,
                                  bus1.frame_done, bus1.busy, bus1.rem}), 32'h80);
        step(); step();
        reset = 1'b0;
        chk("midreset_no_done", 32'(fd_cnt[0] - f0), 32'd0);
        send(8'h03); wait_idle();
        chk("sel_0x03", 32'(lg_sel[0]), 32'h03);
        chk("nbits_0x03", 32'(lg_n[0]), 32'd8);
        chk("remseq_0x03", 32'(lg_rem[0]), 32'h0004);

        // Random words with random gaps, some arriving while busy
        repeat (40) begin
            send(W'($urandom));
            repeat ($urandom_range(0, 10)) step();
        end
        wait_idle();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mod3_bit_serializer.md
# mod3_bit_serializer

Upstream feeder for the mod-3 divisibility FSM. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first on `sel`, one bit per divider tick, so the FSM's `cout` can be checked bit by bit. It also keeps a running mod-3 residue of the bits already emitted, which the bench compares against `cout`. Timing uses a single clock domain: a clock-enable tick replaces any derived clock.

## Interface
- `WIDTH`, default 8: bits per frame, ≥1.
- `DIV`, default 4: clock cycles per serial bit, ≥1. `DIV=1` means one bit every cycle.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `load_valid`  in  1  source has a word on `load_data`.
- `load_data`  in  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- `load_ready`  out  1  block can accept a word; combinational, equals `state==IDLE`.
- `sel`  out  1  serial bit to the FSM; registered; held between ticks.
- `bit_valid`  out  1  one-cycle strobe on the cycle `sel` takes a new frame bit.
- `frame_start`  out  1  one-cycle strobe, coincident with `bit_valid` of the first bit.
- `frame_done`  out  1  one-cycle strobe, coincident with `bit_valid` of the last bit.
- `busy`  out  1  high from the accept edge until the `frame_done` edge.
- `rem`  out  2  mod-3 residue of the bits emitted so far in the current frame.

## Operation
- Divider
  - `cnt` runs free from 0 to DIV-1 and wraps; `tick = (cnt==DIV-1)`.
  - It is not resynchronised to loads.
- States
  - IDLE: `load_ready=1`. On `load_valid & load_ready`, capture `load_data` into `shreg`, set `bitcnt=WIDTH`, set `first=1`, go to SHIFT.
  - SHIFT: on each `tick` edge:
    - `sel<=shreg[WIDTH-1]`; `shreg` shifts left with 0 fill; `bitcnt` decrements.
    - `bit_valid<=1`; `frame_start<=first`; `first<=0`.
    - `rem<=(2*rem+bit) mod 3`, except on the first bit, where `rem<=bit mod 3` (the residue restarts each frame).
    - If `bitcnt==1`: `frame_done<=1` and go to IDLE.
- Residue update `(rem,bit)->rem`: (0,0)->0, (0,1)->1, (1,0)->2, (1,1)->0, (2,0)->1, (2,1)->2. The value 3 is never reachable.
- `rem` and `sel` hold their last values in IDLE until the first bit of the next frame.
- `load_valid` while busy: ignored, not captured. The source must hold `load_valid` until it sees ready.
- `load_data` is sampled only on the accept edge; later changes do not affect the frame.

## Timing
- Reset values, all applied asynchronously:
  - State IDLE, so `load_ready=1`.
  - `sel=0`, `bit_valid=0`, `frame_start=0`, `frame_done=0`, `busy=0`, `rem=0`, `cnt=0`, `shreg=0`.
- Accept-to-first-bit latency: the first bit appears at the first tick edge strictly after the accept edge. That is 1 to DIV cycles, depending on the `cnt` phase.
- Bit spacing: exactly DIV cycles between consecutive `bit_valid` strobes within a frame.
- Frame length: WIDTH `bit_valid` strobes. `frame_done` and the final `rem` appear on the last one.
- `load_ready` rises in the cycle after the `frame_done` edge. A new word can be accepted on the next edge (back-to-back).
- Accept on the same edge as a tick: the tick is not used. The first bit goes out on the following tick.
- Reset mid-frame: the frame is aborted. There is no `frame_done` and the partial residue is discarded. After reset deasserts, the block is in IDLE and ready.

## Test plan
- Reset: assert `reset` mid-cycle. Immediately all outputs take their reset values and `load_ready=1`. Hold `load_valid=0` for 20 cycles: no strobes.
- WIDTH=8, DIV=4, load 0x0F:
  - `sel` = 0,0,0,0,1,1,1,1, each bit held 4 cycles.
  - Exactly 8 `bit_valid` strobes; `frame_start` on the 1st, `frame_done` on the 8th.
  - `rem` sequence 0,0,0,0,1,0,1,0; final `rem=0`; FSM `cout` agrees.
- Load 0xB5: bits 1,0,1,1,0,1,0,1; `rem` sequence 1,2,2,2,1,0,0,1; final `rem=1` (181 mod 3).
- Back-to-back 0x07 then 0x08, with `load_valid` held high:
  - Second accept occurs in the cycle after the first `frame_done`.
  - Final `rem` = 1 for 0x07, then 2 for 0x08.
  - `frame_start` fires once per frame; the residue does not carry over between frames.
- Load 0x00; during bit 3, drive `load_valid=1` with `load_data=0xFF`: not captured (`load_ready=0`). The frame completes with `sel=0` throughout and `rem=0`. The pending 0xFF is accepted after `frame_done`.
- Reset mid-frame: load 0xAA; assert `reset` after the 3rd `bit_valid`. Outputs clear, with no `frame_done`. Then load 0x03: all 8 bits are emitted and final `rem=0`.
- DIV=1: load 0x05. Expect 8 consecutive `bit_valid` cycles; final `rem=2`.
